// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
//   arb_state_t : arbiter FSM states (IDLE, REQ, RESP)
//   arb_grant_t : which requester owns the current access
//   ERR_WORD    : response word returned when the memory never acknowledges
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } arb_grant_t;

  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_wdog.sv
// Clearable, saturating watchdog counter for the memory port arbiter.
// Ports:
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   clr_i     : restart the count from zero (takes priority over en_i)
//   en_i      : count one cycle of waiting
//   expired_o : count has reached TIMEOUT (held until cleared)
module mem_arb_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values and simulation matches hardware.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != LIMIT)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one backing-memory port between the instruction-fetch requester and
// the data (MEM-stage) requester. One access at a time, data has priority,
// and a watchdog turns a missing acknowledge into an error response.
// Ports:
//   clk_i, rst_i                        : clock, synchronous active-high reset
//   if_req_i, if_addr_i                 : fetch request / address
//   if_rdata_o, if_ready_o              : fetch response word / completion pulse
//   d_req_i, d_we_i, d_addr_i, d_wdata_i: data request, store flag, address, data
//   d_rdata_o, d_ready_o                : data response word / completion pulse
//   mem_req_o, mem_we_o, mem_addr_o,
//   mem_wdata_o                         : memory request side
//   mem_rdata_i, mem_ack_i              : memory response side
//   stall_o                             : pipeline stall while a request is open
//   err_o                               : sticky timeout flag
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              err_o
);

  arb_state_t        state_q, state_d;
  arb_grant_t        grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] resp_q;
  logic              err_q;
  logic              wdog_clr, wdog_en, wdog_expired;

  mem_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (wdog_clr),
    .en_i      (wdog_en),
    .expired_o (wdog_expired)
  );

  // Reset puts every register, including the datapath latches, in a known
  // state so the memory side sees all-zero outputs straight out of reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    wdog_clr = 1'b0;
    wdog_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (d_req_i || if_req_i) begin
          state_d  = REQ;
          wdog_clr = 1'b1;
        end
      end
      REQ: begin
        wdog_en = 1'b1;
        // An ack in the same cycle the watchdog expires still wins.
        if (mem_ack_i || wdog_expired) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latches change only on entry to REQ; response captured in REQ.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_q <= GNT_I;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      resp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (d_req_i) begin
            grant_q <= GNT_D;
            addr_q  <= d_addr_i;
            we_q    <= d_we_i;
            wdata_q <= d_wdata_i;
          end else if (if_req_i) begin
            grant_q <= GNT_I;
            addr_q  <= if_addr_i;
            we_q    <= 1'b0;
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            resp_q <= mem_rdata_i;
          end else if (wdog_expired) begin
            resp_q <= DATA_W'(ERR_WORD);
            err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign if_ready_o  = (state_q == RESP) && (grant_q == GNT_I);
  assign d_ready_o   = (state_q == RESP) && (grant_q == GNT_D);
  assign if_rdata_o  = resp_q;
  assign d_rdata_o   = resp_q;

  assign stall_o     = (if_req_i & ~if_ready_o) | (d_req_i & ~d_ready_o);
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Inputs are driven and
// outputs sampled on the falling clock edge, away from the active edge.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ready_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_ready_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;
  logic              stall_o;
  logic              err_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_ready_o  (if_ready_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_rdata_o   (d_rdata_o),
    .d_ready_o   (d_ready_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .stall_o     (stall_o),
    .err_o       (err_o)
  );

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req_o); end
    n_cmp++; if ({mem_we_o, mem_addr_o, mem_wdata_o} !== '0) begin n_bad++; $display("FAIL reset_mem_bus: we=%b addr=%h wdata=%h want all 0", mem_we_o, mem_addr_o, mem_wdata_o); end
    n_cmp++; if ({if_ready_o, d_ready_o} !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b want 00", {if_ready_o, d_ready_o}); end
    n_cmp++; if ({if_rdata_o, d_rdata_o} !== '0) begin n_bad++; $display("FAIL reset_rdata: if=%h d=%h want 0", if_rdata_o, d_rdata_o); end
    n_cmp++; if ({err_o, stall_o} !== 2'b00) begin n_bad++; $display("FAIL reset_err_stall: got %b want 00", {err_o, stall_o}); end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_fetch();
    if_req_i = 1'b1; if_addr_i = 32'h0000_0010;
    #1;
    n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL fetch_stall_req_cycle: got %b want 1", stall_o); end
    n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL fetch_mem_req_t: got %b want 0", mem_req_o); end
    @(negedge clk_i);
    n_cmp++; if ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h0000_0010}) begin n_bad++; $display("FAIL fetch_issue: req=%b we=%b addr=%h want 1 0 00000010", mem_req_o, mem_we_o, mem_addr_o); end
    n_cmp++; if ({stall_o, if_ready_o} !== 2'b10) begin n_bad++; $display("FAIL fetch_stall_wait: stall/ready=%b want 10", {stall_o, if_ready_o}); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_0513;
    @(negedge clk_i);
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    n_cmp++; if ({if_ready_o, d_ready_o, mem_req_o, stall_o} !== 4'b1000) begin n_bad++; $display("FAIL fetch_pulse: ifr/dr/req/stall=%b want 1000", {if_ready_o, d_ready_o, mem_req_o, stall_o}); end
    n_cmp++; if (if_rdata_o !== 32'h0000_0513) begin n_bad++; $display("FAIL fetch_rdata: got %h want 00000513", if_rdata_o); end
    if_req_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if ({if_ready_o, mem_req_o, stall_o} !== 3'b000) begin n_bad++; $display("FAIL fetch_after: ifr/req/stall=%b want 000", {if_ready_o, mem_req_o, stall_o}); end
  endtask

  task automatic test_priority();
    if_req_i = 1'b1; if_addr_i = 32'h0000_0100;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0040;
    @(negedge clk_i);
    n_cmp++; if ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h0000_0040}) begin n_bad++; $display("FAIL prio_data_first: req=%b we=%b addr=%h want 1 0 00000040", mem_req_o, mem_we_o, mem_addr_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A5_A5A5;
    @(negedge clk_i);
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    n_cmp++; if ({d_ready_o, if_ready_o, stall_o} !== 3'b101) begin n_bad++; $display("FAIL prio_d_pulse: dr/ifr/stall=%b want 101", {d_ready_o, if_ready_o, stall_o}); end
    n_cmp++; if (d_rdata_o !== 32'hA5A5_A5A5) begin n_bad++; $display("FAIL prio_d_rdata: got %h want a5a5a5a5", d_rdata_o); end
    d_req_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (mem_req_o !== 1'b0) begin n_bad++; $display("FAIL prio_idle_gap: mem_req=%b want 0", mem_req_o); end
    @(negedge clk_i);
    n_cmp++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0000_0100}) begin n_bad++; $display("FAIL prio_fetch_issue: req=%b addr=%h want 1 00000100", mem_req_o, mem_addr_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_0013;
    @(negedge clk_i);
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    n_cmp++; if ({if_ready_o, d_ready_o, if_rdata_o} !== {2'b10, 32'h0000_0013}) begin n_bad++; $display("FAIL prio_fetch_pulse: ifr=%b dr=%b rdata=%h want 1 0 00000013", if_ready_o, d_ready_o, if_rdata_o); end
    if_req_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_store();
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0000_0080; d_wdata_i = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      n_cmp++; if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {2'b11, 32'h0000_0080, 32'h1234_5678}) begin
        n_bad++; $display("FAIL store_hold_%0d: req=%b we=%b addr=%h wdata=%h want 1 1 00000080 12345678", i, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
      end
    end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0BAD_0001;
    @(negedge clk_i);
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    n_cmp++; if ({d_ready_o, if_ready_o} !== 2'b10) begin n_bad++; $display("FAIL store_pulse: dr/ifr=%b want 10", {d_ready_o, if_ready_o}); end
    d_req_i = 1'b0; d_we_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if ({d_ready_o, mem_req_o} !== 2'b00) begin n_bad++; $display("FAIL store_single_pulse: dr/req=%b want 00", {d_ready_o, mem_req_o}); end
  endtask

  task automatic test_timeout();
    int hi_cycles = 0;
    bit got = 1'b0;
    logic [DATA_W-1:0] rd = '0;
    n_cmp++; if (err_o !== 1'b0) begin n_bad++; $display("FAIL timeout_err_before: got %b want 0", err_o); end
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_00C0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (mem_req_o) hi_cycles++;
      if (d_ready_o) begin got = 1'b1; rd = d_rdata_o; break; end
    end
    d_req_i = 1'b0;
    n_cmp++; if (!got) begin n_bad++; $display("FAIL timeout_no_ready: no d_ready_o within 40 cycles"); end
    n_cmp++; if (hi_cycles !== TIMEOUT + 1) begin n_bad++; $display("FAIL timeout_req_len: got %0d cycles want %0d", hi_cycles, TIMEOUT + 1); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL timeout_rdata: got %h want deadbeef", rd); end
    repeat (3) @(negedge clk_i);
    n_cmp++; if (err_o !== 1'b1) begin n_bad++; $display("FAIL timeout_err_sticky: got %b want 1", err_o); end
  endtask

  task automatic test_reset_mid();
    bit bad_pulse = 1'b0;
    bit bad_req = 1'b0;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h0000_0200;
    @(negedge clk_i);
    n_cmp++; if (mem_req_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_req: mem_req=%b want 1", mem_req_o); end
    rst_i = 1'b1; d_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    n_cmp++; if ({mem_req_o, err_o} !== 2'b00) begin n_bad++; $display("FAIL rstmid_drop: req/err=%b want 00", {mem_req_o, err_o}); end
    for (int i = 0; i < 5; i++) begin
      mem_ack_i = (i == 0); mem_rdata_i = 32'h0000_0077;
      @(negedge clk_i);
      if (if_ready_o || d_ready_o) bad_pulse = 1'b1;
      if (mem_req_o) bad_req = 1'b1;
    end
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    n_cmp++; if (bad_pulse !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_pulse: saw ready pulse %b want 0", bad_pulse); end
    n_cmp++; if (bad_req !== 1'b0) begin n_bad++; $display("FAIL rstmid_stay_idle: saw mem_req %b want 0", bad_req); end
    n_cmp++; if (d_rdata_o !== 32'h0) begin n_bad++; $display("FAIL rstmid_late_ack: rdata=%h want 00000000", d_rdata_o); end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int first = -1;
    int last = -1;
    bit bad_gap = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h0000_0300;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0000_1111;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk_i);
      if (if_ready_o) begin
        if (first < 0) first = i;
        else if (i - last != 3) bad_gap = 1'b1;
        last = i;
        pulses++;
      end
    end
    if_req_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    n_cmp++; if (pulses !== 4) begin n_bad++; $display("FAIL b2b_count: got %0d pulses want 4", pulses); end
    n_cmp++; if (first !== 2) begin n_bad++; $display("FAIL b2b_first: got cycle %0d want 2", first); end
    n_cmp++; if (bad_gap !== 1'b0) begin n_bad++; $display("FAIL b2b_interval: irregular gap %b want 0", bad_gap); end
    n_cmp++; if (if_rdata_o !== 32'h0000_1111) begin n_bad++; $display("FAIL b2b_rdata: got %h want 00001111", if_rdata_o); end
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
    mem_rdata_i = '0; mem_ack_i = 1'b0;
    @(negedge clk_i);
    test_reset();
    test_fetch();
    test_priority();
    test_store();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
